// File: rtl/ofdm_demap_pkg.sv
// rtl/ofdm_demap_pkg.sv - mode encodings, bits-per-mode table and slicer threshold multipliers
// QAM_DEMAPPER_QAM64_EN: mode 3 decodes as QAM64 (13-bit packer); otherwise as QAM16 (11-bit packer).
package ofdm_demap_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_QAM64 = 2'd3
  } mode_e;

  localparam logic [2:0] BITS_BPSK  = 3'd1;
  localparam logic [2:0] BITS_QPSK  = 3'd2;
  localparam logic [2:0] BITS_QAM16 = 3'd4;
  localparam logic [2:0] BITS_QAM64 = 3'd6;

  localparam logic [2:0] THR_M2 = 3'd2;
  localparam logic [2:0] THR_M4 = 3'd4;
  localparam logic [2:0] THR_M6 = 3'd6;

`ifdef QAM_DEMAPPER_QAM64_EN
  localparam bit QAM64_EN = 1'b1;
  localparam int ACC_W    = 13;
`else
  localparam bit QAM64_EN = 1'b0;
  localparam int ACC_W    = 11;
`endif

  function automatic mode_e eff_mode(input logic [1:0] m);
    if ((m == MODE_QAM64) && !QAM64_EN) return MODE_QAM16;
    return mode_e'(m);
  endfunction

  function automatic logic [2:0] bits_per_mode(input mode_e m);
    case (m)
      MODE_BPSK:  return BITS_BPSK;
      MODE_QPSK:  return BITS_QPSK;
      MODE_QAM16: return BITS_QAM16;
      default:    return BITS_QAM64;
    endcase
  endfunction

endpackage

// File: rtl/qam_axis_slicer.sv
// rtl/qam_axis_slicer.sv - combinational per-axis hard decision, bits = {sign, m1/m, m0}
module qam_axis_slicer
  import ofdm_demap_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] scale,
  input  mode_e       mode,
  output logic [2:0]  bits
);

  logic [18:0] mag;
  logic [18:0] t2;
  logic [18:0] t4;
  logic [18:0] t6;

  always_comb begin
    // 0x8000 has no positive twin; saturate so it slices as the outermost level
    if (!x[15])             mag = {3'b000, x};
    else if (x == 16'h8000) mag = 19'h07FFF;
    else                    mag = {3'b000, (~x + 16'd1)};
    t2 = {3'b000, scale} * {16'd0, THR_M2};
    t4 = {3'b000, scale} * {16'd0, THR_M4};
    t6 = {3'b000, scale} * {16'd0, THR_M6};
    bits = {x[15], 2'b00};
    case (mode)
      MODE_QAM16: bits[1] = (mag < t2);
      MODE_QAM64: begin
        bits[1] = (mag < t4);
        bits[0] = (mag >= t2) && (mag < t6);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/qam_demapper.sv
// rtl/qam_demapper.sv - hard-decision QAM demapper: registered slicer stage feeding a bit packer
// QAM_DEMAPPER_QAM64_EN selects native QAM64 decoding of mode 3 (see ofdm_demap_pkg).
module qam_demapper
  import ofdm_demap_pkg::*;
#(
  parameter logic [15:0] SCALE = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [31:0] sym_data,
  input  logic        sym_valid,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        byte_last,
  input  logic        byte_ready
);

  mode_e      sym_mode;
  logic [2:0] i_bits;
  logic [2:0] q_bits;
  logic [2:0] sym_cnt;
  logic [5:0] sym_bits;

  assign sym_mode = eff_mode(mode);

  qam_axis_slicer u_slice_i (.x(sym_data[31:16]), .scale(SCALE), .mode(sym_mode), .bits(i_bits));
  qam_axis_slicer u_slice_q (.x(sym_data[15:0]),  .scale(SCALE), .mode(sym_mode), .bits(q_bits));

  // decided bits are left-aligned so the first bit always sits at bit 5
  always_comb begin
    sym_cnt = bits_per_mode(sym_mode);
    case (sym_mode)
      MODE_BPSK:  sym_bits = {i_bits[2], 5'b0};
      MODE_QPSK:  sym_bits = {i_bits[2], q_bits[2], 4'b0};
      MODE_QAM16: sym_bits = {i_bits[2:1], q_bits[2:1], 2'b0};
      default:    sym_bits = {i_bits, q_bits};
    endcase
  end

  logic             run;
  logic             s1_valid;
  logic [5:0]       s1_bits;
  logic [2:0]       s1_cnt;
  logic             s1_last;
  logic [ACC_W-1:0] acc;
  logic [3:0]       cnt;
  logic             pend_last;

  logic             out_free;
  logic             flush;
  logic             emit;
  logic             pend_after;
  logic             load;
  logic [3:0]       cnt_after;
  logic [4:0]       fill;
  logic [ACC_W-1:0] acc_shift;
  logic [ACC_W-1:0] acc_ins;

  always_comb begin
    out_free  = !byte_valid || byte_ready;
    flush     = pend_last && (cnt <= 4'd8);
    emit      = out_free && ((cnt >= 4'd8) || flush);
    cnt_after = cnt;
    acc_shift = acc;
    if (emit) begin
      cnt_after = flush ? 4'd0 : (cnt - 4'd8);
      acc_shift = acc << 8;
    end
    // a pending flush blocks new bits until its byte is in the output register
    pend_after = pend_last && !(emit && flush);
    fill       = {1'b0, cnt_after} + {2'b00, s1_cnt};
    load       = s1_valid && !pend_after && (fill <= 5'(ACC_W));
    acc_ins    = {s1_bits, {(ACC_W-6){1'b0}}} >> cnt_after;
    sym_ready  = run && (!s1_valid || load);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run        <= 1'b0;
      s1_valid   <= 1'b0;
      s1_bits    <= '0;
      s1_cnt     <= '0;
      s1_last    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      pend_last  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_last  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (sym_valid && sym_ready) begin
        s1_valid <= 1'b1;
        s1_bits  <= sym_bits;
        s1_cnt   <= sym_cnt;
        s1_last  <= sym_last;
      end else if (load) begin
        s1_valid <= 1'b0;
      end
      acc       <= load ? (acc_shift | acc_ins) : acc_shift;
      cnt       <= load ? fill[3:0] : cnt_after;
      pend_last <= pend_after || (load && s1_last);
      if (emit) begin
        byte_valid <= 1'b1;
        byte_data  <= acc[ACC_W-1 -: 8];
        byte_last  <= flush;
      end else if (byte_ready) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_demapper.sv
// tb/tb_qam_demapper.sv - directed self-checking bench for qam_demapper
module tb_qam_demapper;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [31:0] sym_data;
  logic        sym_valid;
  logic        sym_last;
  logic        sym_ready;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;

  int checks;
  int failures;

  logic [7:0] q_data[$];
  logic       q_last[$];

  logic [31:0] pts[4] = '{32'h0800_0800, 32'h0800_F800, 32'hF800_0800, 32'hF800_F800};

`ifdef QAM_DEMAPPER_QAM64_EN
  localparam logic [7:0] EXP_Q64 = 8'h1C;
`else
  localparam logic [7:0] EXP_Q64 = 8'h20;
`endif

  qam_demapper #(.SCALE(16'h0800)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_last(sym_last), .sym_ready(sym_ready), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst && byte_valid && byte_ready) begin
      q_data.push_back(byte_data);
      q_last.push_back(byte_last);
    end
  end

  task automatic send(input logic [1:0] m, input logic [31:0] d, input logic l);
    logic ok;
    mode = m; sym_data = d; sym_last = l; sym_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = sym_ready;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout got=no_accept exp=accept data=%h", d);
    end
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (q_data.size() < n && k < 300) begin @(posedge clk); #1; k++; end
    if (q_data.size() < n) begin
      checks++; failures++;
      $display("FAIL wait_bytes got=%0d exp=%0d", q_data.size(), n);
    end
  endtask

  task automatic pop(output logic [7:0] d, output logic l);
    if (q_data.size() > 0) begin d = q_data.pop_front(); l = q_last.pop_front(); end
    else begin d = 8'hxx; l = 1'bx; end
  endtask

  task automatic test_reset;
    rst = 1'b0; mode = 2'd0; sym_data = '0; sym_valid = 1'b0; sym_last = 1'b0; byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL rst_byte_valid got=%b exp=0", byte_valid); end
    checks++; if (byte_data !== 8'h00) begin failures++; $display("FAIL rst_byte_data got=%h exp=00", byte_data); end
    checks++; if (byte_last !== 1'b0) begin failures++; $display("FAIL rst_byte_last got=%b exp=0", byte_last); end
    checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL rst_sym_ready got=%b exp=0", sym_ready); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL release_sym_ready got=%b exp=0", sym_ready); end
    @(posedge clk); #1;
    checks++; if (sym_ready !== 1'b1) begin failures++; $display("FAIL run_sym_ready got=%b exp=1", sym_ready); end
  endtask

  task automatic test_qpsk;
    logic [7:0] d; logic l;
    for (int k = 0; k < 4; k++) send(2'd1, pts[k], k == 3);
    sym_valid = 1'b0;
    wait_bytes(1);
    pop(d, l);
    checks++; if (d !== 8'h1B) begin failures++; $display("FAIL qpsk_data got=%h exp=1b", d); end
    checks++; if (l !== 1'b1) begin failures++; $display("FAIL qpsk_last got=%b exp=1", l); end
    repeat (6) @(posedge clk); #1;
    checks++; if (q_data.size() != 0) begin failures++; $display("FAIL qpsk_no_pad got=%0d exp=0", q_data.size()); end
  endtask

  task automatic test_qam16_latency;
    logic [7:0] d; logic l;
    send(2'd2, 32'h1800_0800, 1'b0);
    send(2'd2, 32'hF800_E800, 1'b1);
    sym_valid = 1'b0;
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL lat_n got=%b exp=0", byte_valid); end
    @(posedge clk); #1;
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL lat_n1 got=%b exp=0", byte_valid); end
    @(posedge clk); #1;
    checks++; if (byte_valid !== 1'b1) begin failures++; $display("FAIL lat_n2 got=%b exp=1", byte_valid); end
    wait_bytes(1);
    pop(d, l);
    checks++; if (d !== 8'h1E) begin failures++; $display("FAIL qam16_data got=%h exp=1e", d); end
    checks++; if (l !== 1'b1) begin failures++; $display("FAIL qam16_last got=%b exp=1", l); end
  endtask

  task automatic test_qam64;
    logic [7:0] d; logic l;
    send(2'd3, 32'h3800_E800, 1'b1);
    sym_valid = 1'b0;
    wait_bytes(1);
    pop(d, l);
    checks++; if (d !== EXP_Q64) begin failures++; $display("FAIL qam64_data got=%h exp=%h", d, EXP_Q64); end
    checks++; if (l !== 1'b1) begin failures++; $display("FAIL qam64_last got=%b exp=1", l); end
  endtask

  task automatic test_thresholds;
    logic [7:0] d; logic l;
    send(2'd2, 32'h1000_0000, 1'b0);
    send(2'd2, 32'h8000_0000, 1'b0);
    send(2'd2, 32'h0000_8000, 1'b1);
    sym_valid = 1'b0;
    wait_bytes(2);
    pop(d, l);
    checks++; if (d !== 8'h19) begin failures++; $display("FAIL thr_byte0 got=%h exp=19", d); end
    checks++; if (l !== 1'b0) begin failures++; $display("FAIL thr_last0 got=%b exp=0", l); end
    pop(d, l);
    checks++; if (d !== 8'h60) begin failures++; $display("FAIL thr_byte1 got=%h exp=60", d); end
    checks++; if (l !== 1'b1) begin failures++; $display("FAIL thr_last1 got=%b exp=1", l); end
  endtask

  task automatic test_mixed_modes;
    logic [7:0] d; logic l;
    send(2'd0, 32'hF800_0000, 1'b0);
    send(2'd2, 32'h0800_F800, 1'b0);
    send(2'd1, 32'hF800_0800, 1'b0);
    send(2'd0, 32'h0800_F800, 1'b0);
    send(2'd1, 32'h0800_F800, 1'b1);
    sym_valid = 1'b0;
    wait_bytes(2);
    pop(d, l);
    checks++; if (d !== 8'hBC) begin failures++; $display("FAIL mixed_byte0 got=%h exp=bc", d); end
    checks++; if (l !== 1'b0) begin failures++; $display("FAIL mixed_last0 got=%b exp=0", l); end
    pop(d, l);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL mixed_byte1 got=%h exp=40", d); end
    checks++; if (l !== 1'b1) begin failures++; $display("FAIL mixed_last1 got=%b exp=1", l); end
  endtask

  task automatic test_backpressure;
    int         seq[20] = '{0,1,2,3, 3,2,1,0, 1,1,2,2, 3,0,3,0, 2,3,0,1};
    logic [7:0] exp_b[5] = '{8'h1B, 8'hE4, 8'h5A, 8'hCC, 8'hB1};
    logic [7:0] d; logic l;
    logic       fell, held, stable_ok, ref_l;
    logic [7:0] ref_d;
    fell = 1'b0; held = 1'b0; stable_ok = 1'b1; ref_d = 8'h00; ref_l = 1'b0;
    byte_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) send(2'd1, pts[seq[k]], k == 19);
        sym_valid = 1'b0;
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (!sym_ready) fell = 1'b1;
          if (byte_valid) begin
            if (!held) begin held = 1'b1; ref_d = byte_data; ref_l = byte_last; end
            else if (byte_data !== ref_d || byte_last !== ref_l) stable_ok = 1'b0;
          end
        end
        @(posedge clk); #1;
        byte_ready = 1'b1;
      end
    join
    checks++; if (fell !== 1'b1) begin failures++; $display("FAIL bp_sym_ready_fall got=%b exp=1", fell); end
    checks++; if ((held && stable_ok) !== 1'b1) begin failures++; $display("FAIL bp_hold_stable got=%b exp=1", held && stable_ok); end
    wait_bytes(5);
    for (int k = 0; k < 5; k++) begin
      pop(d, l);
      checks++; if (d !== exp_b[k]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", k, d, exp_b[k]); end
      checks++; if (l !== (k == 4)) begin failures++; $display("FAIL bp_last%0d got=%b exp=%b", k, l, k == 4); end
    end
  endtask

  task automatic test_reset_midburst;
    logic [7:0] d; logic l;
    int k;
    byte_ready = 1'b0;
    for (int j = 0; j < 4; j++) send(2'd1, pts[j], 1'b0);
    send(2'd1, pts[3], 1'b0);
    send(2'd1, pts[3], 1'b0);
    sym_valid = 1'b0;
    k = 0;
    while (!byte_valid && k < 50) begin @(posedge clk); #1; k++; end
    checks++; if (byte_valid !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", byte_valid); end
    rst = 1'b0;
    #1;
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", byte_valid); end
    checks++; if (byte_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h exp=00", byte_data); end
    checks++; if (sym_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", sym_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    q_data.delete(); q_last.delete();
    byte_ready = 1'b1;
    send(2'd2, 32'h0800_0800, 1'b1);
    sym_valid = 1'b0;
    wait_bytes(1);
    pop(d, l);
    checks++; if (d !== 8'h50) begin failures++; $display("FAIL mid_new_data got=%h exp=50", d); end
    checks++; if (l !== 1'b1) begin failures++; $display("FAIL mid_new_last got=%b exp=1", l); end
    repeat (10) @(posedge clk); #1;
    checks++; if (q_data.size() != 0) begin failures++; $display("FAIL mid_no_stale got=%0d exp=0", q_data.size()); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_qpsk();
    test_qam16_latency();
    test_qam64();
    test_thresholds();
    test_mixed_modes();
    test_backpressure();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qam_demapper.md
QAM_DEMAPPER -- requirements
Module: qam_demapper

Interface
REQ-001 Parameter: SCALE, 16'h0800, unit amplitude A; constellation levels are odd multiples of A.
REQ-002 Port: clk  in  1  clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: mode  in  2  modulation of the offered symbol: 0 BPSK, 1 QPSK, 2 QAM16, 3 QAM64.
REQ-005 Port: sym_data  in  32  symbol; [31:16] I, [15:0] Q, both signed two's complement.
REQ-006 Port: sym_valid  in  1  symbol offered.
REQ-007 Port: sym_last  in  1  symbol is last of burst; qualified by sym_valid.
REQ-008 Port: sym_ready  out  1  block accepts symbol this cycle.
REQ-009 Port: byte_data  out  8  packed decided bits; first decided bit in bit 7.
REQ-010 Port: byte_valid  out  1  byte_data valid.
REQ-011 Port: byte_last  out  1  final byte of burst; qualified by byte_valid.
REQ-012 Port: byte_ready  in  1  downstream accepts byte.

Function
REQ-013 Symbol transfers when sym_valid&&sym_ready; byte transfers when byte_valid&&byte_ready.
REQ-014 mode and sym_last are captured with each symbol; mode may change between any two symbols, even mid-byte.
REQ-015 Per-axis decision, x = I or Q: s = (x<0); |x| saturates (0x8000 -> 0x7FFF); a value equal to a threshold takes the larger-magnitude side.
REQ-016 BPSK: 1 bit {s_I}; Q ignored.
REQ-017 QPSK: 2 bits {s_I,s_Q} (+1+1j->00, +1-1j->01, -1+1j->10, -1-1j->11).
REQ-018 QAM16: 4 bits {s_I,m_I,s_Q,m_Q}, m = (|x|<2A).
REQ-019 QAM64: 6 bits {s_I,m1_I,m0_I,s_Q,m1_Q,m0_Q}, m1 = (|x|<4A), m0 = (2A<=|x|<6A); Gray order +7..-7: 000,001,011,010,110,111,101,100.
REQ-020 Pipeline: stage 1 registered slicer (bits, count, last); stage 2 packer with 13-bit accumulator and bit count.
REQ-021 Packer emits a byte when its count >=8 and the output register is empty or draining this cycle.
REQ-022 Stage-1 contents enter the packer only if the post-drain count plus bit count <=13; otherwise stage 1 holds.
REQ-023 sym_ready = stage 1 empty, or stage 1 moving to the packer this cycle.
REQ-024 Minimum latency: symbol accepted at edge N gives byte_valid at edge N+2 when that symbol completes a byte.
REQ-025 On last: once the last symbol's bits are in the packer, the remaining bits go out zero-padded in the low positions with byte_last=1.
REQ-026 If the remainder is exactly 0 after a full byte, that full byte carries byte_last=1 and no pad byte is emitted.
REQ-027 Symbols after a last symbol are not accepted into the packer until the flush byte has been loaded into the output register.
REQ-028 byte_data and byte_last are held stable while byte_valid=1 and byte_ready=0.
REQ-029 No symbol or bit is dropped or duplicated under any backpressure pattern.

Reset
REQ-030 While rst=0: byte_valid=0, byte_data=8'h00, byte_last=0, sym_ready=0; stage 1 and packer are cleared.
REQ-031 sym_ready=1 is first seen after the first rising clk edge following rst release; reset mid-burst discards all partial bits.

Configuration
REQ-032 Macro QAM_DEMAPPER_QAM64_EN.
REQ-033 Defined: mode 3 is decoded as QAM64 per REQ-019.
REQ-034 Undefined: mode 3 is decoded as QAM16; accumulator shrinks to 11 bits and the REQ-022 limit becomes 11.

Structure
REQ-035 Shared package ofdm_demap_pkg holds the mode encoding constants, the bits-per-mode table (1,2,4,6) and the threshold multipliers (2,4,6).
REQ-036 One sub-module, qam_axis_slicer, does the combinational per-axis decision (x, SCALE, mode -> 3 bits) and is instantiated for I and for Q.

Verification
REQ-037 QPSK, byte_ready=1: 0x0800_0800, 0x0800_F800, 0xF800_0800, 0xF800_F800 (last on 4th) -> one byte 0x1B, byte_last=1.
REQ-038 QAM16: 0x1800_0800, then 0xF800_E800 with last -> byte 0x1E, byte_last=1.
REQ-039 QAM64: one symbol 0x3800_E800 with last -> byte 0x1C, byte_last=1 (bits 000111 plus 2 pad zeros).
REQ-040 Thresholds, QAM16: I=0x1000 -> m_I=0; I=0x0000 -> s_I=0; I=0x8000 -> s_I=1, m_I=0.
REQ-041 Backpressure: continuous QPSK stream with byte_ready=0 for 20 cycles -> sym_ready falls, byte_data stable; after release the byte sequence equals the no-backpressure reference.
REQ-042 Reset: rst=0 while byte_valid=1 -> byte_valid=0 immediately; after release the first byte comes only from new symbols.
